// File: rtl/pio_pkg.sv
// Shared widths, FSM state encoding and default timeout data for the PIO master.
package pio_pkg;
  localparam int PIO_AW = 16;
  localparam int PIO_DW = 32;
  localparam logic [PIO_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} pio_state_e;
endpackage

// File: rtl/pio_if.sv
// PIO bus between one command master and a register/table target.
interface pio_if;
  import pio_pkg::*;
  logic              cmd_vld;
  logic              rw;
  logic [PIO_AW-1:0] addr;
  logic [PIO_DW-1:0] data_w;
  logic [PIO_DW-1:0] data_r;
  logic              rd_vld;

  modport master (output cmd_vld, rw, addr, data_w, input data_r, rd_vld);
  modport target (input cmd_vld, rw, addr, data_w, output data_r, rd_vld);
endinterface

// File: rtl/pio_timeout_ctr.sv
// Read-wait counter: cleared on issue, counts while enabled, flags the final cycle.
module pio_timeout_ctr #(
  parameter int TC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(TC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // tc fires in the cycle whose increment brings the count to TC
  assign tc = en && (cnt_q == CW'(TC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && (cnt_q != CW'(TC)))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pio_master.sv
// Single-outstanding PIO master: host req/resp stream to pio_if cycles, with read timeout.
module pio_master
  import pio_pkg::*;
#(
  parameter int                TIMEOUT_CYC = 16,
  parameter logic [PIO_DW-1:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_rw,
  input  logic [PIO_AW-1:0] req_addr,
  input  logic [PIO_DW-1:0] req_wdata,
  output logic              resp_vld,
  input  logic              resp_rdy,
  output logic [PIO_DW-1:0] resp_rdata,
  output logic              resp_err,
  output logic [7:0]        timeout_cnt,
  pio_if.master             pio
);
  pio_state_e        state_q;
  logic              req_rdy_q, resp_vld_q, resp_err_q, cmd_vld_q, rw_q;
  logic [PIO_DW-1:0] resp_rdata_q, data_w_q;
  logic [PIO_AW-1:0] addr_q;
  logic [7:0]        timeout_cnt_q;
  logic              ctr_tc;

  pio_timeout_ctr #(.TC(TIMEOUT_CYC)) u_ctr (
    .clk (clk),
    .rst (reset),
    .clr (state_q == ISSUE),
    .en  (state_q == WAIT_RD),
    .tc  (ctr_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      req_rdy_q     <= 1'b1;
      resp_vld_q    <= 1'b0;
      resp_rdata_q  <= '0;
      resp_err_q    <= 1'b0;
      timeout_cnt_q <= '0;
      cmd_vld_q     <= 1'b0;
      rw_q          <= 1'b0;
      addr_q        <= '0;
      data_w_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_vld) begin
          state_q   <= ISSUE;
          req_rdy_q <= 1'b0;
          cmd_vld_q <= 1'b1;
          rw_q      <= req_rw;
          addr_q    <= req_addr;
          data_w_q  <= req_wdata;
        end
        ISSUE: begin
          cmd_vld_q <= 1'b0;
          if (rw_q) begin
            state_q      <= RESP;
            resp_vld_q   <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
          end else begin
            state_q <= WAIT_RD;
          end
        end
        // Data arriving on the terminal cycle still counts as a good read
        WAIT_RD: if (pio.rd_vld) begin
          state_q      <= RESP;
          resp_vld_q   <= 1'b1;
          resp_rdata_q <= pio.data_r;
          resp_err_q   <= 1'b0;
        end else if (ctr_tc) begin
          state_q      <= RESP;
          resp_vld_q   <= 1'b1;
          resp_rdata_q <= ERR_DATA;
          resp_err_q   <= 1'b1;
          if (timeout_cnt_q != 8'hFF) timeout_cnt_q <= timeout_cnt_q + 8'd1;
        end
        RESP: if (resp_rdy) begin
          state_q    <= IDLE;
          resp_vld_q <= 1'b0;
          req_rdy_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_rdy     = req_rdy_q;
  assign resp_vld    = resp_vld_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;
  assign timeout_cnt = timeout_cnt_q;
  assign pio.cmd_vld = cmd_vld_q;
  assign pio.rw      = rw_q;
  assign pio.addr    = addr_q;
  assign pio.data_w  = data_w_q;
endmodule

// File: tb/tb_pio_master.sv
// Directed bench for pio_master with a configurable-latency PIO target stub.
module tb_pio_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_vld = 1'b0, req_rw = 1'b0, resp_rdy = 1'b1;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_rdy, resp_vld, resp_err;
  logic [31:0] resp_rdata;
  logic [7:0]  timeout_cnt;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  pio_if bus();

  pio_master #(.TIMEOUT_CYC(16), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset), .req_vld(req_vld), .req_rdy(req_rdy), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_vld(resp_vld), .resp_rdy(resp_rdy),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .timeout_cnt(timeout_cnt), .pio(bus)
  );

  // Target stub: rd_delay 1 behaves like blockA, 0 never answers, >1 answers late.
  int          cyc = 0, cmd_cnt = 0, cmd_cyc = 0, rd_delay = 1, dly = 0;
  bit          pend = 1'b0;
  logic        stub_rd_vld = 1'b0;
  logic [31:0] stub_data = '0, pend_data = '0;
  logic [31:0] mem [256];

  assign bus.rd_vld = stub_rd_vld;
  assign bus.data_r = stub_data;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    stub_rd_vld <= 1'b0;
    if (pend) begin
      if (dly == 1) begin stub_rd_vld <= 1'b1; stub_data <= pend_data; pend <= 1'b0; end
      else dly <= dly - 1;
    end
    if (bus.cmd_vld) begin
      cmd_cnt <= cmd_cnt + 1;
      cmd_cyc <= cyc;
      if (bus.rw) mem[bus.addr[7:0]] <= bus.data_w;
      else if (rd_delay == 1) begin stub_rd_vld <= 1'b1; stub_data <= mem[bus.addr[7:0]]; end
      else if (rd_delay > 1) begin pend <= 1'b1; dly <= rd_delay - 1; pend_data <= mem[bus.addr[7:0]]; end
    end
  end

  // Stimulus helpers; called at a negedge, return at a negedge.
  task automatic send_req(input logic rw, input logic [15:0] a, input logic [31:0] d, output int c);
    int k = 0;
    while (!req_rdy && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) begin n_cmp++; n_err++; $display("FAIL req_rdy_wait: got 0 want 1 within 50 cycles"); end
    req_vld = 1'b1; req_rw = rw; req_addr = a; req_wdata = d;
    c = cyc;
    @(negedge clk);
    req_vld = 1'b0;
  endtask

  task automatic wait_resp(input int c, output int lat, output logic [31:0] rd, output logic er);
    int k = 0;
    lat = -1; rd = '0; er = 1'b0;
    while (k < 100) begin
      @(negedge clk); k++;
      if (resp_vld) begin lat = cyc - c; rd = resp_rdata; er = resp_err; break; end
    end
    if (lat < 0) begin n_cmp++; n_err++; $display("FAIL resp_wait: got no resp_vld want resp_vld within 100 cycles"); end
  endtask

  task automatic do_req(input logic rw, input logic [15:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
    int c;
    send_req(rw, a, d, c);
    wait_resp(c, lat, rd, er);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (req_rdy !== 1'b1)      begin n_err++; $display("FAIL rst_req_rdy: got %b want 1", req_rdy); end
    n_cmp++; if (resp_vld !== 1'b0)     begin n_err++; $display("FAIL rst_resp_vld: got %b want 0", resp_vld); end
    n_cmp++; if (resp_rdata !== 32'h0)  begin n_err++; $display("FAIL rst_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (timeout_cnt !== 8'h0)  begin n_err++; $display("FAIL rst_tcnt: got %0d want 0", timeout_cnt); end
    n_cmp++; if (bus.cmd_vld !== 1'b0)  begin n_err++; $display("FAIL rst_cmd_vld: got %b want 0", bus.cmd_vld); end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (req_rdy !== 1'b1)      begin n_err++; $display("FAIL rst_rel_req_rdy: got %b want 1", req_rdy); end
  endtask

  task automatic test_blocka();
    int c, lat, c0; logic [31:0] rd; logic er;
    rd_delay = 1;
    c0 = cmd_cnt;
    send_req(1'b1, 16'h8005, 32'hA5A5_0001, c);
    n_cmp++; if (bus.cmd_vld !== 1'b1)  begin n_err++; $display("FAIL wr_cmd_vld: got %b want 1", bus.cmd_vld); end
    n_cmp++; if (req_rdy !== 1'b0)      begin n_err++; $display("FAIL wr_req_rdy_low: got %b want 0", req_rdy); end
    wait_resp(c, lat, rd, er);
    n_cmp++; if (lat != 2)              begin n_err++; $display("FAIL wr_latency: got %0d want 2", lat); end
    n_cmp++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL wr_resp: got %h/%b want 0/0", rd, er); end
    n_cmp++; if (cmd_cnt != c0 + 1)     begin n_err++; $display("FAIL wr_cmd_pulses: got %0d want 1", cmd_cnt - c0); end
    n_cmp++; if (cmd_cyc != c + 1)      begin n_err++; $display("FAIL wr_cmd_cycle: got +%0d want +1", cmd_cyc - c); end
    @(negedge clk);
    c0 = cmd_cnt;
    send_req(1'b0, 16'h0005, 32'h0, c);
    wait_resp(c, lat, rd, er);
    n_cmp++; if (lat != 3)              begin n_err++; $display("FAIL rd_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hA5A5_0001)  begin n_err++; $display("FAIL rd_data: got %h want a5a50001", rd); end
    n_cmp++; if (er !== 1'b0)           begin n_err++; $display("FAIL rd_err: got %b want 0", er); end
    n_cmp++; if (cmd_cnt != c0 + 1)     begin n_err++; $display("FAIL rd_cmd_pulses: got %0d want 1", cmd_cnt - c0); end
    @(negedge clk);
    n_cmp++; if (req_rdy !== 1'b1 || resp_vld !== 1'b0) begin n_err++; $display("FAIL rd_handshake: got rdy %b vld %b want 1 0", req_rdy, resp_vld); end
  endtask

  task automatic test_timeout();
    int c, lat; logic [31:0] rd; logic er;
    rd_delay = 0;
    send_req(1'b0, 16'h0040, 32'h0, c);
    wait_resp(c, lat, rd, er);
    n_cmp++; if (lat != 18)             begin n_err++; $display("FAIL to_latency: got %0d want 18", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF)  begin n_err++; $display("FAIL to_data: got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b1)           begin n_err++; $display("FAIL to_err: got %b want 1", er); end
    n_cmp++; if (timeout_cnt !== 8'd1)  begin n_err++; $display("FAIL to_cnt: got %0d want 1", timeout_cnt); end
    @(negedge clk);
  endtask

  task automatic test_terminal_race();
    int c, lat; logic [31:0] rd; logic er;
    rd_delay = 1;
    do_req(1'b1, 16'h0012, 32'h0000_1234, lat, rd, er);
    rd_delay = 16;
    send_req(1'b0, 16'h0012, 32'h0, c);
    wait_resp(c, lat, rd, er);
    n_cmp++; if (lat != 18)             begin n_err++; $display("FAIL race_latency: got %0d want 18", lat); end
    n_cmp++; if (rd !== 32'h0000_1234)  begin n_err++; $display("FAIL race_data: got %h want 00001234", rd); end
    n_cmp++; if (er !== 1'b0)           begin n_err++; $display("FAIL race_err: got %b want 0", er); end
    n_cmp++; if (timeout_cnt !== 8'd1)  begin n_err++; $display("FAIL race_cnt: got %0d want 1", timeout_cnt); end
    @(negedge clk);
    rd_delay = 1;
  endtask

  task automatic test_backpressure();
    int c, lat, c0; logic [31:0] rd; logic er;
    resp_rdy = 1'b0;
    send_req(1'b0, 16'h0005, 32'h0, c);
    wait_resp(c, lat, rd, er);
    req_vld = 1'b1; req_rw = 1'b1; req_addr = 16'h8007; req_wdata = 32'h0000_0077;
    c0 = cmd_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_vld !== 1'b1 || resp_rdata !== 32'hA5A5_0001 || resp_err !== 1'b0 || req_rdy !== 1'b0 || cmd_cnt != c0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got vld %b data %h err %b rdy %b cmds %0d want 1 a5a50001 0 0 0",
                 i, resp_vld, resp_rdata, resp_err, req_rdy, cmd_cnt - c0);
      end
    end
    resp_rdy = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_rdy !== 1'b1 || resp_vld !== 1'b0) begin n_err++; $display("FAIL bp_release: got rdy %b vld %b want 1 0", req_rdy, resp_vld); end
    @(negedge clk);
    req_vld = 1'b0;
    n_cmp++; if (bus.cmd_vld !== 1'b1 || bus.addr !== 16'h8007) begin n_err++; $display("FAIL bp_next_cmd: got %b %h want 1 8007", bus.cmd_vld, bus.addr); end
    @(negedge clk);
    n_cmp++; if (resp_vld !== 1'b1 || resp_rdata !== 32'h0) begin n_err++; $display("FAIL bp_next_resp: got %b %h want 1 0", resp_vld, resp_rdata); end
    n_cmp++; if (cmd_cnt != c0 + 1)     begin n_err++; $display("FAIL bp_cmd_pulses: got %0d want 1", cmd_cnt - c0); end
    @(negedge clk);
    do_req(1'b0, 16'h0007, 32'h0, lat, rd, er);
    n_cmp++; if (rd !== 32'h0000_0077)  begin n_err++; $display("FAIL bp_readback: got %h want 00000077", rd); end
  endtask

  task automatic test_reset_mid();
    int c, lat, c0; logic [31:0] rd; logic er; bit saw;
    rd_delay = 10;
    send_req(1'b0, 16'h0005, 32'h0, c);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_cmp++; if (resp_vld !== 1'b0 || req_rdy !== 1'b1 || timeout_cnt !== 8'd0 || bus.cmd_vld !== 1'b0)
      begin n_err++; $display("FAIL rstw_outputs: got vld %b rdy %b tcnt %0d cmd %b want 0 1 0 0", resp_vld, req_rdy, timeout_cnt, bus.cmd_vld); end
    n_cmp++; if (bus.rw !== 1'b0 || bus.addr !== 16'h0 || bus.data_w !== 32'h0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
      begin n_err++; $display("FAIL rstw_bus: got rw %b addr %h dw %h rd %h err %b want all 0", bus.rw, bus.addr, bus.data_w, resp_rdata, resp_err); end
    @(negedge clk);
    reset = 1'b0;
    c0 = cmd_cnt; saw = 1'b0;
    repeat (15) begin @(negedge clk); if (resp_vld || !req_rdy) saw = 1'b1; end
    n_cmp++; if (saw || cmd_cnt != c0)  begin n_err++; $display("FAIL rstw_late_rd: got resp/busy %b cmds %0d want 0 0", saw, cmd_cnt - c0); end
    rd_delay = 1;
    do_req(1'b0, 16'h0005, 32'h0, lat, rd, er);
    n_cmp++; if (lat != 3 || rd !== 32'hA5A5_0001 || er !== 1'b0) begin n_err++; $display("FAIL rstw_next_rd: got %0d %h %b want 3 a5a50001 0", lat, rd, er); end
    // Reset while the command is on the bus drops cmd_vld without waiting for a clock
    send_req(1'b1, 16'h8010, 32'h1111_2222, c);
    n_cmp++; if (bus.cmd_vld !== 1'b1)  begin n_err++; $display("FAIL rsti_cmd_before: got %b want 1", bus.cmd_vld); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.cmd_vld !== 1'b0 || bus.addr !== 16'h0) begin n_err++; $display("FAIL rsti_cmd_async: got %b %h want 0 0000", bus.cmd_vld, bus.addr); end
    @(negedge clk);
    reset = 1'b0;
    saw = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_vld) saw = 1'b1; end
    n_cmp++; if (saw)                   begin n_err++; $display("FAIL rsti_no_resp: got resp_vld want none"); end
  endtask

  task automatic test_saturate();
    int lat; logic [31:0] rd; logic er;
    rd_delay = 0;
    repeat (254) do_req(1'b0, 16'h0050, 32'h0, lat, rd, er);
    n_cmp++; if (timeout_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", timeout_cnt); end
    do_req(1'b0, 16'h0050, 32'h0, lat, rd, er);
    n_cmp++; if (timeout_cnt !== 8'd255) begin n_err++; $display("FAIL sat_255: got %0d want 255", timeout_cnt); end
    repeat (45) do_req(1'b0, 16'h0050, 32'h0, lat, rd, er);
    n_cmp++; if (timeout_cnt !== 8'd255) begin n_err++; $display("FAIL sat_300: got %0d want 255", timeout_cnt); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF || er !== 1'b1) begin n_err++; $display("FAIL sat_resp: got %h %b want deadbeef 1", rd, er); end
  endtask

  initial begin
    test_reset();
    test_blocka();
    test_timeout();
    test_terminal_race();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pio_master.md
# pio_master

Single-outstanding PIO command master that turns a host-side valid/ready request/response stream into `pio_if` cycles for a register/table target such as blockA. It is a single-state-machine bridge:
- Writes are fire-and-acknowledge.
- Reads wait for `rd_vld` from the target. A programmable timeout guards against a silent target and returns an error response.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 16: cycles in WAIT_RD before a read is declared timed out; legal range 2..255.
- `ERR_DATA`, default 32'hDEAD_BEEF: `resp_rdata` value returned on timeout.

Ports:
- `clk`  input  1  single clock; all logic on its rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req_vld`  input  1  host request valid.
- `req_rdy`  output  1  block can accept a request (IDLE only).
- `req_rw`  input  1  1 = write, 0 = read.
- `req_addr`  input  16  target address.
- `req_wdata`  input  32  write data.
- `resp_vld`  output  1  response valid; held until `resp_rdy`.
- `resp_rdy`  input  1  host accepts response.
- `resp_rdata`  output  32  read data (0 for writes).
- `resp_err`  output  1  1 = read timed out.
- `timeout_cnt`  output  8  saturating count of timeouts since reset.
- `pio_if`  interface  —  master side of the PIO bus:
  - drives `cmd_vld`, `rw`, `addr[15:0]`, `data_w[31:0]`;
  - samples `data_r[31:0]`, `rd_vld`.

## Operation
- States: IDLE, ISSUE, WAIT_RD, RESP (enum in package).
- IDLE: `req_rdy`=1. On `req_vld`, latch rw/addr/wdata and go to ISSUE.
- ISSUE: `cmd_vld`=1 for exactly one cycle, with latched rw/addr/data_w.
  - Write: go to RESP with rdata=0, err=0.
  - Read: clear the timeout counter and go to WAIT_RD.
- WAIT_RD: counter increments each cycle.
  - `rd_vld`=1: capture `data_r`, err=0, go to RESP.
  - Else, counter reaches `TIMEOUT_CYC`: rdata=`ERR_DATA`, err=1, increment `timeout_cnt` (saturate at 255), go to RESP.
  - `rd_vld` in the same cycle the counter hits `TIMEOUT_CYC`: `rd_vld` wins, no error.
- RESP: `resp_vld`=1, with rdata/err stable until `resp_rdy`; then go to IDLE.
  - `resp_rdy` held high gives back-to-back transactions with no extra bubble beyond IDLE.
- `rd_vld` outside WAIT_RD (a late response after timeout) is ignored and not buffered.
- `cmd_vld` is never asserted outside ISSUE. At most one command is outstanding.
- All outputs, including `pio_if` drives, are registered.

## Timing
- Reset values: state IDLE; `req_rdy`=1, `resp_vld`=0, `resp_rdata`=0, `resp_err`=0, `timeout_cnt`=0; `cmd_vld`=0, `rw`=0, `addr`=0, `data_w`=0.
- Reset asserted mid-transaction aborts it immediately: no response is issued, `cmd_vld` drops asynchronously.
- Request accepted at edge N: `cmd_vld` is high in cycle N+1.
- Write latency: `resp_vld` in cycle N+2.
- Read latency with blockA (rd_vld one cycle after cmd_vld): `rd_vld` in N+2, `resp_vld` in N+3.
- Timeout read: `resp_vld` in cycle N+2+`TIMEOUT_CYC`.
- `req_rdy` deasserts the cycle after acceptance and reasserts the cycle after the response handshake.

## Structure
- Package `pio_pkg`:
  - `PIO_AW`=16, `PIO_DW`=32;
  - `pio_state_e` {IDLE, ISSUE, WAIT_RD, RESP};
  - default `ERR_DATA` constant.
- Sub-module `pio_timeout_ctr`: clear/enable/terminal-count counter sized `$clog2(TIMEOUT_CYC+1)`. The saturating `timeout_cnt` stays inline.

## Test plan
- Write 0x8005/0xA5A5_0001, then read 0x0005 against blockA:
  - exactly one `cmd_vld` pulse per request;
  - write response in N+2, err=0;
  - read response in N+3 with rdata=0xA5A5_0001, err=0.
- Read against a stub that never asserts `rd_vld`, `TIMEOUT_CYC`=16: `resp_vld` in N+18, rdata=0xDEAD_BEEF, err=1, `timeout_cnt`=1.
- Stub raises `rd_vld` exactly at count 16 with data 0x0000_1234: rdata=0x0000_1234, err=0, `timeout_cnt` unchanged.
- `resp_rdy` held low 5 cycles: `resp_vld`/rdata/err stable, `req_rdy`=0, no new `cmd_vld` while `req_vld` is high; release, and the next request is issued.
- Reset pulsed in WAIT_RD: no `resp_vld`, all outputs at reset values; a late `rd_vld` after reset is ignored; the next read completes normally.
- 300 forced timeouts: `timeout_cnt` saturates at 255.
